func_param: RTL and testbench
=============================

FUNC_PARAM -- requirements
Module: func_param

Interface
REQ-001 Parameter W SHALL be: W, default 8, operand width; even, legal range 4..16.
REQ-002 Port clk_i SHALL be: clk_i  input  1  sole clock, rising-edge.
REQ-003 Port rst_i SHALL be: rst_i  input  1  reset, synchronous, active-high.
REQ-004 Port start_i SHALL be: start_i  input  1  request; sampled only in IDLE.
REQ-005 Port mode_i SHALL be: mode_i  input  1  0: y=a^3+isqrt(b); 1: y=a^2+isqrt(b); sampled with start.
REQ-006 Port a_i SHALL be: a_i  input  W  unsigned operand a.
REQ-007 Port b_i SHALL be: b_i  input  W  unsigned operand b.
REQ-008 Port busy_o SHALL be: busy_o  output  1  high while an operation is in flight.
REQ-009 Port done_o SHALL be: done_o  output  1  one-cycle pulse, y_o newly valid.
REQ-010 Port y_o SHALL be: y_o  output  3W  registered result, held until the next result.

Function
REQ-011 FSM states SHALL be IDLE, MUL1, MUL2 and ADD; busy_o SHALL equal (state != IDLE).
REQ-012 IDLE with start_i=1 at edge T0 SHALL:
- latch a_i, b_i and mode_i;
- clear the accumulators;
- start the isqrt sub-module;
- enter MUL1.
REQ-013 MUL1 SHALL compute a*a with a shift-add multiplier, one bit per cycle, W cycles, then go to MUL2 if mode=0 or ADD if mode=1.
REQ-014 MUL2 SHALL compute (a*a)*a, one bit of a per cycle, W cycles, then go to ADD.
REQ-015 isqrt(b) SHALL be floor(sqrt(b)), digit-by-digit, W/2 cycles, running concurrently with MUL1 and complete before MUL1 ends.
REQ-016 ADD, one cycle, SHALL:
- register y_o = product + zero-extended root;
- assert done_o for the following cycle;
- return to IDLE.
REQ-017 Latency from the T0 edge to the done_o cycle SHALL be exactly 2W+1 clocks for mode 0 and W+1 for mode 1, independent of operand values, including zero operands.
REQ-018 All arithmetic SHALL be unsigned; 3W bits SHALL suffice (max (2^W-1)^3 + 2^(W/2)-1 < 2^(3W)) and no overflow path SHALL exist.
REQ-019 start_i while busy_o=1 SHALL be ignored; latched operands SHALL be unaffected by input changes during an operation.
REQ-020 start_i in the done_o cycle (state IDLE) SHALL be accepted, giving back-to-back operation with no idle gap.
REQ-021 y_o SHALL hold its last result while busy and idle, and change only in ADD or on reset.

Reset
REQ-022 rst_i=1 at an edge SHALL force state=IDLE, y_o=0, done_o=0 and busy_o=0, and SHALL reset the isqrt sub-module.
REQ-023 Reset mid-operation SHALL discard partial results; no done_o SHALL follow for the aborted operation.
REQ-024 Reset SHALL take priority over start_i on the same edge.

Structure
REQ-025 Shared package func_param_pkg SHALL hold:
- the state encoding constants (IDLE/MUL1/MUL2/ADD);
- the mode constants MODE_CUBE=0 and MODE_SQUARE=1.
REQ-026 Sub-module isqrt_iter #(W) SHALL be used, with ports clk_i, rst_i, start_i, x_i[W-1:0], busy_o, y_o[W/2-1:0].
REQ-027 The multiplier SHALL be a single shift-add datapath inside func_param, reused for MUL1 and MUL2.

Verification (W=8)
REQ-028 a=3, b=16, mode 0 SHALL give y_o=31 with done_o exactly 17 clocks after the start edge.
REQ-029 a=255, b=255, mode 0 SHALL give y_o=16581390 (max case, no overflow).
REQ-030 a=0, b=0, mode 0 SHALL give y_o=0 with done_o at 17 clocks (zero operands terminate normally).
REQ-031 a=12, b=100, mode 1 SHALL give y_o=154 with done_o at 9 clocks; a second start in the done_o cycle with a=2, b=9, mode 0 SHALL give y_o=11 at 17 clocks after its start.
REQ-032 a=5, b=4 start, then start_i with a=9 at cycle 3 while busy, SHALL give y_o=127, a single done_o, and the second request ignored.
REQ-033 rst_i asserted at cycle 6 of an operation SHALL give busy_o=0, y_o=0 and no done_o on the next edge; a fresh start SHALL then complete correctly.

Source files
------------

// File: rtl/func_param_pkg.sv
// Shared encodings for the func_param datapath: FSM states and operation modes.
package func_param_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL1 = 2'd1,
    MUL2 = 2'd2,
    ADD  = 2'd3
  } state_t;

  localparam logic MODE_CUBE   = 1'b0;
  localparam logic MODE_SQUARE = 1'b1;

endpackage

// File: rtl/isqrt_iter.sv
// Iterative integer square root, floor(sqrt(x)), two radicand bits per cycle.
// Finishes W/2 cycles after start_i; y_o holds the root until the next start.
module isqrt_iter #(
  parameter int W = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic [W-1:0]   x_i,
  output logic           busy_o,
  output logic [W/2-1:0] y_o
);

  localparam int H  = W / 2;
  localparam int RW = H + 3;
  localparam int CW = $clog2(H);
  localparam logic [CW-1:0] CNT_LAST = CW'(H - 1);

  logic [W-1:0]  x_reg;
  logic [RW-1:0] rem_reg;
  logic [H-1:0]  root_reg;
  logic [CW-1:0] cnt_reg;
  logic          busy_reg;

  logic [RW-1:0] rem_sh;
  logic [RW-1:0] trial;
  logic          fits;

  // Bring down the next two radicand bits and try appending a 1 to the root.
  assign rem_sh = (rem_reg << 2) | RW'(x_reg[W-1:W-2]);
  assign trial  = {1'b0, root_reg, 2'b01};
  assign fits   = (rem_sh >= trial);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_reg    <= '0;
      rem_reg  <= '0;
      root_reg <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
    end else if (start_i) begin
      x_reg    <= x_i;
      rem_reg  <= '0;
      root_reg <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b1;
    end else if (busy_reg) begin
      x_reg    <= x_reg << 2;
      rem_reg  <= fits ? (rem_sh - trial) : rem_sh;
      root_reg <= {root_reg[H-2:0], fits};
      cnt_reg  <= cnt_reg + 1'b1;
      if (cnt_reg == CNT_LAST) begin
        busy_reg <= 1'b0;
      end
    end
  end

  assign busy_o = busy_reg;
  assign y_o    = root_reg;

endmodule

// File: rtl/func_param.sv
// y = a^3 + isqrt(b) (mode 0) or a^2 + isqrt(b) (mode 1), using one shift-add
// multiplier reused for both squaring and cubing; fixed latency 2W+1 / W+1.
module func_param
  import func_param_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic           mode_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [3*W-1:0] y_o
);

  localparam int YW = 3 * W;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_t          state_reg, state_next;
  logic [W-1:0]    a_reg, a_next;
  logic            mode_reg, mode_next;
  logic [YW-1:0]   mcand_reg, mcand_next;
  logic [W-1:0]    mplier_reg, mplier_next;
  logic [YW-1:0]   acc_reg, acc_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [YW-1:0]   y_reg, y_next;
  logic            done_reg, done_next;

  logic            sq_start;
  logic            sq_busy;
  logic [W/2-1:0]  sq_root;
  logic [YW-1:0]   sum;

  isqrt_iter #(.W(W)) u_isqrt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (sq_start),
    .x_i     (b_i),
    .busy_o  (sq_busy),
    .y_o     (sq_root)
  );

  assign sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    mode_next   = mode_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    acc_next    = acc_reg;
    cnt_next    = cnt_reg;
    y_next      = y_reg;
    done_next   = 1'b0;
    sq_start    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_i) begin
          a_next      = a_i;
          mode_next   = mode_i;
          mcand_next  = {{(2*W){1'b0}}, a_i};
          mplier_next = a_i;
          acc_next    = '0;
          cnt_next    = '0;
          sq_start    = 1'b1;
          state_next  = MUL1;
        end
      end
      MUL1, MUL2: begin
        acc_next    = sum;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        cnt_next    = cnt_reg + 1'b1;
        if (cnt_reg == CNT_LAST) begin
          cnt_next = '0;
          if (state_reg == MUL1 && mode_reg == MODE_CUBE) begin
            // Feed a*a back in as the multiplicand for the second pass.
            mcand_next  = sum;
            mplier_next = a_reg;
            acc_next    = '0;
            state_next  = MUL2;
          end else begin
            state_next = ADD;
          end
        end
      end
      ADD: begin
        y_next     = acc_reg + {{(YW - W/2){1'b0}}, sq_root};
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      mode_reg   <= MODE_CUBE;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      y_reg      <= '0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      mode_reg   <= mode_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      acc_reg    <= acc_next;
      cnt_reg    <= cnt_next;
      y_reg      <= y_next;
      done_reg   <= done_next;
    end
  end

  // The root unit always finishes inside MUL1, so including it never widens busy.
  assign busy_o = (state_reg != IDLE) | sq_busy;
  assign done_o = done_reg;
  assign y_o    = y_reg;

endmodule

// File: tb/tb_func_param.sv
// Randomized self-checking bench for func_param (W=8) against an arithmetic
// reference: result value, fixed latency, single done pulse, result hold, reset.
module tb_func_param;

  localparam int W = 8;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           start_i;
  logic           mode_i;
  logic [W-1:0]   a_i;
  logic [W-1:0]   b_i;
  logic           busy_o;
  logic           done_o;
  logic [3*W-1:0] y_o;

  int n_tests = 0;
  int n_fail  = 0;
  longint last_y = 0;

  func_param #(.W(W)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .mode_i  (mode_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .y_o     (y_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint ref_y(input longint a, input longint b, input bit m);
    longint p;
    longint r;
    p = m ? a * a : a * a * a;
    r = 0;
    while ((r + 1) * (r + 1) <= b) r++;
    return p + r;
  endfunction

  // One operation: start on the next edge, optionally hammer start_i/inputs while
  // busy, then expect the result at exactly the fixed latency. Returns in the
  // done cycle so a following call starts back-to-back.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit m,
                       input bit inject);
    longint exp_y;
    int     exp_lat;
    int     n;
    bit     hold_ok;
    exp_y   = ref_y(a, b, m);
    exp_lat = m ? W + 1 : 2 * W + 1;
    @(negedge clk_i);
    start_i = 1'b1;
    a_i = a;
    b_i = b;
    mode_i = m;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    a_i = W'($urandom);
    b_i = W'($urandom);
    mode_i = 1'($urandom);
    check("busy_after_start", busy_o, 1);
    check("done_low_after_start", done_o, 0);
    hold_ok = (y_o === last_y[3*W-1:0]);
    n = 0;
    while (done_o !== 1'b1 && n < 60) begin
      if (inject) begin
        start_i = 1'($urandom);
        a_i = W'($urandom);
        b_i = W'($urandom);
        mode_i = 1'($urandom);
      end
      @(posedge clk_i);
      #1;
      n++;
      if (done_o !== 1'b1 && y_o !== last_y[3*W-1:0]) hold_ok = 1'b0;
    end
    start_i = 1'b0;
    $display("[TB] op a=%0d b=%0d mode=%0d -> y=%0d (exp %0d) after %0d clks",
             a, b, m, y_o, exp_y, n);
    check("latency", n, exp_lat);
    check("y", y_o, exp_y);
    check("y_hold", hold_ok, 1);
    last_y = exp_y;
  endtask

  task automatic reset_mid_op();
    int saw_done;
    @(negedge clk_i);
    start_i = 1'b1;
    a_i = 8'd200;
    b_i = 8'd77;
    mode_i = 1'b0;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_y", y_o, 0);
    check("rst_done", done_o, 0);
    rst_i = 1'b0;
    start_i = 1'b0;
    saw_done = 0;
    repeat (2 * W + 4) begin
      @(posedge clk_i);
      #1;
      if (done_o === 1'b1) saw_done++;
    end
    $display("[TB] reset mid-operation, done pulses afterwards=%0d", saw_done);
    check("no_done_after_rst", saw_done, 0);
    check("idle_after_rst", busy_o, 0);
    last_y = 0;
  endtask

  initial begin
    rst_i = 1'b1;
    start_i = 1'b0;
    mode_i = 1'b0;
    a_i = '0;
    b_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_y", y_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    do_op(8'd3, 8'd16, 1'b0, 1'b0);
    do_op(8'd255, 8'd255, 1'b0, 1'b0);
    do_op(8'd0, 8'd0, 1'b0, 1'b0);
    do_op(8'd12, 8'd100, 1'b1, 1'b0);
    do_op(8'd2, 8'd9, 1'b0, 1'b0);
    do_op(8'd5, 8'd4, 1'b0, 1'b1);
    @(posedge clk_i);
    #1;
    check("single_done_pulse", done_o, 0);
    reset_mid_op();
    do_op(8'd7, 8'd50, 1'b1, 1'b0);
    do_op(8'd255, 8'd255, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
